// File: rtl/io_key_sw_port.sv
// rtl/io_key_sw_port.sv - memory-mapped key/switch port with debounce and change interrupts (optional IO_KEY_SW_INTR_EN)
`timescale 1ns/1ps
module io_key_sw_port #(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr_in,
  input  logic [DBITS-1:0] data_in,
  input  logic             we_in,
  input  logic             re_in,
  output logic [DBITS-1:0] data_out,
  input  logic [3:0]       key_in,
  input  logic [9:0]       sw_in,
  output logic             intr_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [DBITS-1:0] KDATA_A = DBITS'(32'hFFFF_F080);
  localparam logic [DBITS-1:0] KCTRL_A = DBITS'(32'hFFFF_F084);
  localparam logic [DBITS-1:0] SDATA_A = DBITS'(32'hFFFF_F090);
  localparam logic [DBITS-1:0] SCTRL_A = DBITS'(32'hFFFF_F094);

  logic [3:0]    key_s1, key_s2, kdata;
  logic [9:0]    sw_s1, sw_s2, sw_cand, sdata;
  logic [CW-1:0] sw_cnt;
  logic          k_rdy, k_ovr, k_ie;
  logic          s_rdy, s_ovr, s_ie;

  logic sel_kdata, sel_kctrl, sel_sdata, sel_sctrl;
  logic k_evt, s_evt;
  logic unused_data;

  assign sel_kdata = (addr_in == KDATA_A);
  assign sel_kctrl = (addr_in == KCTRL_A);
  assign sel_sdata = (addr_in == SDATA_A);
  assign sel_sctrl = (addr_in == SCTRL_A);

  // Key data follows the synchronized keys every cycle, so any difference is a change.
  assign k_evt = (key_s2 != kdata);
  // Switches publish only once the candidate has been stable for the full window.
  assign s_evt = (sw_cnt == CNT_MAX) && (sw_cand != sdata);

  // Only a few data_in bits are meaningful; fold the rest away.
  assign unused_data = ^data_in;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
    end
  end

  // Key data register, reloaded every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) kdata <= '0;
    else        kdata <= key_s2;
  end

  // Debounce: restart the count whenever the input moves off the candidate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_cand <= '0;
      sw_cnt  <= '0;
    end else if (sw_s2 != sw_cand) begin
      sw_cand <= sw_s2;
      sw_cnt  <= '0;
    end else if (sw_cnt != CNT_MAX) begin
      sw_cnt <= sw_cnt + 1'b1;
    end
  end

  // Switch data register, updated from a settled candidate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     sdata <= '0;
    else if (s_evt) sdata <= sw_cand;
  end

  // Key status: clears first, then a change event wins; overrun needs a prior Ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_rdy <= 1'b0;
      k_ovr <= 1'b0;
    end else begin
      if (re_in && sel_kdata) k_rdy <= 1'b0;
      if (we_in && sel_kctrl) begin
        if (!data_in[0]) k_rdy <= 1'b0;
        if (!data_in[2]) k_ovr <= 1'b0;
      end
      if (k_evt) begin
        k_rdy <= 1'b1;
        if (k_rdy) k_ovr <= 1'b1;
      end
    end
  end

  // Switch status: same rules as the key status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_rdy <= 1'b0;
      s_ovr <= 1'b0;
    end else begin
      if (re_in && sel_sdata) s_rdy <= 1'b0;
      if (we_in && sel_sctrl) begin
        if (!data_in[0]) s_rdy <= 1'b0;
        if (!data_in[2]) s_ovr <= 1'b0;
      end
      if (s_evt) begin
        s_rdy <= 1'b1;
        if (s_rdy) s_ovr <= 1'b1;
      end
    end
  end

`ifdef IO_KEY_SW_INTR_EN
  // Interrupt enables, loaded by any control write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_ie <= 1'b0;
      s_ie <= 1'b0;
    end else begin
      if (we_in && sel_kctrl) k_ie <= data_in[8];
      if (we_in && sel_sctrl) s_ie <= data_in[8];
    end
  end

  assign intr_out = (k_rdy & k_ie) | (s_rdy & s_ie);
`else
  assign k_ie     = 1'b0;
  assign s_ie     = 1'b0;
  assign intr_out = 1'b0;
`endif

  // Zero-latency read mux; unselected addresses read zero.
  always_comb begin
    data_out = '0;
    if (sel_kdata) data_out[3:0] = kdata;
    if (sel_sdata) data_out[9:0] = sdata;
    if (sel_kctrl) begin
      data_out[0] = k_rdy;
      data_out[2] = k_ovr;
      data_out[8] = k_ie;
    end
    if (sel_sctrl) begin
      data_out[0] = s_rdy;
      data_out[2] = s_ovr;
      data_out[8] = s_ie;
    end
  end

endmodule

// File: tb/tb_io_key_sw_port.sv
// tb/tb_io_key_sw_port.sv - scoreboard bench for io_key_sw_port
`timescale 1ns/1ps
module tb_io_key_sw_port;
  localparam logic [31:0] A_KDATA = 32'hFFFF_F080;
  localparam logic [31:0] A_KCTRL = 32'hFFFF_F084;
  localparam logic [31:0] A_SDATA = 32'hFFFF_F090;
  localparam logic [31:0] A_SCTRL = 32'hFFFF_F094;
`ifdef IO_KEY_SW_INTR_EN
  localparam logic [31:0] IE_BIT  = 32'h100;
  localparam logic        INTR_ON = 1'b1;
`else
  localparam logic [31:0] IE_BIT  = 32'h0;
  localparam logic        INTR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic        we_in = 1'b0;
  logic        re_in = 1'b0;
  logic [31:0] data_out;
  logic [3:0]  key_in = '0;
  logic [9:0]  sw_in = '0;
  logic        intr_out;

  always #5 clk = ~clk;

  io_key_sw_port #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in),
    .we_in(we_in), .re_in(re_in), .data_out(data_out),
    .key_in(key_in), .sw_in(sw_in), .intr_out(intr_out)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] got;
  int          total = 0;
  int          bad   = 0;

  task automatic push(input string n, input logic [31:0] a, input logic [31:0] v);
    exp_t x;
    x.name = n; x.addr = a; x.val = v;
    exp_q.push_back(x);
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr_in = a;
    #0.2;
    d = data_out;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_in = a; data_in = d; we_in = 1'b1;
    @(negedge clk);
    we_in = 1'b0; data_in = '0; addr_in = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_in = a; re_in = 1'b1;
    #0.2;
    d = data_out;
    @(negedge clk);
    re_in = 1'b0; addr_in = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    push("rst_kdata", A_KDATA, 0); push("rst_kctrl", A_KCTRL, 0);
    push("rst_sdata", A_SDATA, 0); push("rst_sctrl", A_SCTRL, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    total++;
    if (intr_out !== 1'b0) begin bad++; $display("FAIL rst_intr: got=%b exp=0", intr_out); end
    reset = 1'b1;
    @(negedge clk);
    bus_write(A_KCTRL, 32'h100);
    key_in = 4'hF;
    repeat (3) @(negedge clk);
    push("busy_kdata", A_KDATA, 32'hF); push("busy_kctrl", A_KCTRL, 32'h1 | IE_BIT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    total++;
    if (intr_out !== INTR_ON) begin bad++; $display("FAIL busy_intr: got=%b exp=%b", intr_out, INTR_ON); end
    sw_in = 10'h3FF;
    repeat (4) @(negedge clk);
    key_in = 4'h0;
    #1 reset = 1'b0;
    #0.2;
    total++;
    if (intr_out !== 1'b0) begin bad++; $display("FAIL midrst_intr: got=%b exp=0", intr_out); end
    push("midrst_kdata", A_KDATA, 0); push("midrst_kctrl", A_KCTRL, 0);
    push("midrst_sdata", A_SDATA, 0); push("midrst_sctrl", A_SCTRL, 0);
    push("unsel", 32'hFFFF_F088, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    push("restart_sdata_early", A_SDATA, 0); push("restart_kdata", A_KDATA, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    @(negedge clk);
    push("restart_sdata", A_SDATA, 32'h3FF); push("restart_sctrl", A_SCTRL, 32'h1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    sw_in = '0;
    #1 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_key_ready();
    key_in = 4'b0010;
    repeat (2) @(negedge clk);
    push("key_early_kdata", A_KDATA, 0); push("key_early_kctrl", A_KCTRL, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    @(negedge clk);
    push("key_kdata", A_KDATA, 32'h2); push("key_kctrl", A_KCTRL, 32'h1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    bus_read(A_KDATA, got);
    total++;
    if (got !== 32'h2) begin bad++; $display("FAIL key_read: got=%h exp=2", got); end
    push("key_after_read", A_KCTRL, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
  endtask

  task automatic test_key_overrun();
    key_in = 4'h1;
    repeat (3) @(negedge clk);
    push("ovr_kctrl1", A_KCTRL, 32'h1); push("ovr_kdata1", A_KDATA, 32'h1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    key_in = 4'h3;
    repeat (3) @(negedge clk);
    push("ovr_kctrl", A_KCTRL, 32'h5); push("ovr_kdata", A_KDATA, 32'h3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    bus_write(A_KCTRL, 32'h4);
    push("ovr_keep", A_KCTRL, 32'h4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    bus_write(A_KCTRL, 32'h0);
    push("ovr_cleared", A_KCTRL, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
  endtask

  task automatic test_sw_glitch();
    sw_in = 10'h2AA;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) sw_in = 10'h000;
      if (i == 4) sw_in = 10'h2AA;
      push($sformatf("glitch_sdata_%0d", i), A_SDATA, 0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); peek(e.addr, got); total++;
        if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
      end
    end
    @(negedge clk);
    push("glitch_sdata", A_SDATA, 32'h2AA); push("glitch_sctrl", A_SCTRL, 32'h1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
  endtask

  task automatic test_sw_intr();
    bit seen = 1'b0;
    bus_write(A_SCTRL, 32'h100);
    push("intr_sctrl_ie", A_SCTRL, IE_BIT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    sw_in = 10'h155;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      peek(A_SDATA, got);
      if (got === 32'h155) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL intr_wait_sdata: got=%h exp=155", got); end
    total++;
    if (intr_out !== INTR_ON) begin bad++; $display("FAIL intr_set: got=%b exp=%b", intr_out, INTR_ON); end
    bus_read(A_SDATA, got);
    total++;
    if (got !== 32'h155) begin bad++; $display("FAIL intr_read: got=%h exp=155", got); end
    total++;
    if (intr_out !== 1'b0) begin bad++; $display("FAIL intr_clear: got=%b exp=0", intr_out); end
    push("intr_sctrl_after", A_SCTRL, IE_BIT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
  endtask

  task automatic test_read_collision();
    key_in = 4'h8;
    repeat (2) @(negedge clk);
    bus_read(A_KDATA, got);
    total++;
    if (got !== 32'h3) begin bad++; $display("FAIL coll_read: got=%h exp=3", got); end
    push("coll_kctrl", A_KCTRL, 32'h1); push("coll_kdata", A_KDATA, 32'h8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
  endtask

  task automatic test_back_to_back();
    bus_write(A_KDATA, 32'hF);
    bus_write(A_SDATA, 32'h0);
    bus_write(A_KCTRL, 32'hFFFF_FFFF);
    push("ro_kdata", A_KDATA, 32'h8); push("ro_sdata", A_SDATA, 32'h155);
    push("keep_kctrl", A_KCTRL, 32'h1 | IE_BIT); push("unsel_low", 32'h0000_0080, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); peek(e.addr, got); total++;
      if (got !== e.val) begin bad++; $display("FAIL %s: got=%h exp=%h", e.name, got, e.val); end
    end
    total++;
    if (intr_out !== INTR_ON) begin bad++; $display("FAIL b2b_intr: got=%b exp=%b", intr_out, INTR_ON); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_key_ready();
    test_key_overrun();
    test_sw_glitch();
    test_sw_intr();
    test_read_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
